player_updater: RTL



---
 rtl/player_updater_pkg.sv | 30 +++
 rtl/player_updater_trig_lut.sv | 23 ++
 rtl/player_updater.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/player_updater_pkg.sv
// Shared definitions for the player pose updater: grid geometry, FSM states
// and the quarter-wave sine table used by trig_lut.
package player_updater_pkg;

  localparam int GRID_W     = 64;
  localparam int GRID_H     = 32;
  localparam int FRAC_BITS  = 8;
  localparam int ANGLE_BITS = 8;

  localparam logic [2:0] GRID_EMPTY = 3'd0;

  typedef enum logic [3:0] {
    S_IDLE, S_TURN, S_CALC, S_READ_X, S_WAIT_X,
    S_CHECK_X, S_READ_Y, S_WAIT_Y, S_CHECK_Y, S_DONE
  } state_t;

  // round(127*sin(2*pi*i/256)) for i = 0..64
  localparam logic [6:0] QSIN [0:64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
    7'd127
  };

endpackage

// File: rtl/player_updater_trig_lut.sv
// Combinational cos/sin (signed Q1.7) of an 8-bit angle, folded from a
// quarter-wave table.
module trig_lut
  import player_updater_pkg::*;
(
  input  logic        [7:0] angle,
  output logic signed [7:0] cos_val,
  output logic signed [7:0] sin_val
);

  function automatic logic signed [7:0] fold(input logic [7:0] a);
    logic [6:0] idx;
    logic [6:0] mag;
    idx = a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
    mag = QSIN[idx];
    return a[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  // cos(a) = sin(a + quarter turn)
  assign sin_val = fold(angle);
  assign cos_val = fold(angle + 8'd64);

endmodule

// File: rtl/player_updater.sv
// Player pose updater: turn, step along heading, per-axis wall test on the grid.
// Build option PU_NOCLIP_EN: skip grid reads, keep only range checks.
module player_updater
  import player_updater_pkg::*;
#(
  parameter int TURN_STEP = 4,
  parameter int MOVE_STEP = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  input  logic        turn_right,
  input  logic        turn_left,
  input  logic        move_forward,
  input  logic        move_backward,
  input  logic [13:0] cur_pos_x,
  input  logic [12:0] cur_pos_y,
  input  logic [7:0]  cur_angle,
  output logic [13:0] next_pos_x,
  output logic [12:0] next_pos_y,
  output logic [7:0]  next_angle,
  output logic [5:0]  grid_x,
  output logic [4:0]  grid_y,
  input  logic [2:0]  grid_out
);

  state_t state, state_nxt;

  logic        tr, tl, mf, mb;
  logic [13:0] pos_x;
  logic [12:0] pos_y;
  logic [7:0]  angle;
  logic signed [14:0] cx, cy;

  logic signed [7:0]  cos_v, sin_v;
  logic signed [14:0] dx, dy, cx_nxt, cy_nxt;
  logic [13:0]        x_acc;
  logic               cx_ok, cy_ok;

  trig_lut u_trig (
    .angle   (angle),
    .cos_val (cos_v),
    .sin_val (sin_v)
  );

  // |t|*MOVE_STEP>>7 with the sign of t reapplied: truncates toward zero
  function automatic logic signed [14:0] scale(input logic signed [7:0] t);
    logic [7:0]  mag;
    logic [14:0] m;
    mag = t[7] ? 8'(-t) : 8'(t);
    m   = 15'((32'(mag) * 32'(MOVE_STEP)) >> 7);
    return t[7] ? -$signed(m) : $signed(m);
  endfunction

  always_comb begin
    dx = scale(cos_v);
    dy = scale(sin_v);
    if (mb && !mf) begin
      dx = -dx;
      dy = -dy;
    end else if (mf == mb) begin
      dx = '0;
      dy = '0;
    end
    cx_nxt = $signed({1'b0, pos_x}) + dx;
    cy_nxt = $signed({2'b0, pos_y}) + dy;
  end

  // bit 14 catches both negative and >= 16384; y additionally needs bit 13 clear
  assign cx_ok = !cx[14];
  assign cy_ok = !cy[14] && !cy[13];
  assign x_acc = (cx_ok && grid_out == GRID_EMPTY) ? cx[13:0] : pos_x;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_TURN;
      S_TURN:    state_nxt = S_CALC;
`ifdef PU_NOCLIP_EN
      S_CALC:    state_nxt = S_DONE;
`else
      S_CALC:    state_nxt = S_READ_X;
`endif
      S_READ_X:  state_nxt = S_WAIT_X;
      S_WAIT_X:  state_nxt = S_CHECK_X;
      S_CHECK_X: state_nxt = S_READ_Y;
      S_READ_Y:  state_nxt = S_WAIT_Y;
      S_WAIT_Y:  state_nxt = S_CHECK_Y;
      S_CHECK_Y: state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      done       <= 1'b0;
      next_pos_x <= '0;
      next_pos_y <= '0;
      next_angle <= '0;
      grid_x     <= '0;
      grid_y     <= '0;
      tr         <= 1'b0;
      tl         <= 1'b0;
      mf         <= 1'b0;
      mb         <= 1'b0;
      pos_x      <= '0;
      pos_y      <= '0;
      angle      <= '0;
      cx         <= '0;
      cy         <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          done  <= 1'b0;
          tr    <= turn_right;
          tl    <= turn_left;
          mf    <= move_forward;
          mb    <= move_backward;
          pos_x <= cur_pos_x;
          pos_y <= cur_pos_y;
          angle <= cur_angle;
        end
        S_TURN: begin
          if (tr && !tl)      angle <= angle + 8'(TURN_STEP);
          else if (tl && !tr) angle <= angle - 8'(TURN_STEP);
        end
        S_CALC: begin
`ifdef PU_NOCLIP_EN
          if (!cx_nxt[14])                pos_x <= cx_nxt[13:0];
          if (!cy_nxt[14] && !cy_nxt[13]) pos_y <= cy_nxt[12:0];
`else
          cx     <= cx_nxt;
          cy     <= cy_nxt;
          grid_x <= cx_nxt[13:8];
          grid_y <= pos_y[12:8];
`endif
        end
        S_CHECK_X: begin
          pos_x  <= x_acc;
          grid_x <= x_acc[13:8];
          grid_y <= cy[12:8];
        end
        S_CHECK_Y: if (cy_ok && grid_out == GRID_EMPTY) pos_y <= cy[12:0];
        S_DONE: begin
          next_pos_x <= pos_x;
          next_pos_y <= pos_y;
          next_angle <= angle;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
